// File: rtl/rgbw_frame_decoder_if.sv
// Byte stream from the SPI slave into the RGBW frame decoder.
interface rgbw_frame_decoder_if;
    logic       rdy;
    logic [7:0] data;
    logic       cs;

    modport master (output rdy, data, cs);
    modport slave  (input  rdy, data, cs);
endinterface

// File: rtl/rgbw_frame_decoder.sv
// Parses header + R/G/B/W byte frames into shadow levels and commits them atomically.
// Define RGBW_FRAME_CHECKSUM_EN to require a trailing XOR checksum byte on colour frames.
module rgbw_frame_decoder #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
    parameter logic [7:0]  HDR_SET        = 8'hA5,
    parameter logic [7:0]  HDR_OFF        = 8'h5A
) (
    input  logic                 clk,
    input  logic                 reset,
    rgbw_frame_decoder_if.slave  bus,
    output logic [7:0]           red,
    output logic [7:0]           green,
    output logic [7:0]           blue,
    output logic [7:0]           white,
    output logic                 update,
    output logic                 frame_err,
    output logic                 busy
);

`ifdef RGBW_FRAME_CHECKSUM_EN
    typedef enum logic [2:0] {ST_IDLE, ST_R, ST_G, ST_B, ST_W, ST_CHK} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_R, ST_G, ST_B, ST_W} state_t;
`endif

    state_t      state;
    state_t      state_next;
    logic        rdy_q;
    logic        take;
    logic        expire;
    logic        commit;
    logic        commit_zero;
    logic        err;
    logic [15:0] idle_cnt;
    logic [7:0]  shadow_r;
    logic [7:0]  shadow_g;
    logic [7:0]  shadow_b;
`ifdef RGBW_FRAME_CHECKSUM_EN
    logic [7:0]  shadow_w;
    logic [7:0]  chk_acc;
`endif

    // Bytes are dropped while cs is high, so an abort can never also advance the frame.
    assign take   = bus.rdy && !rdy_q && !bus.cs;
    assign expire = (TIMEOUT_CYCLES != '0) && (state != ST_IDLE) &&
                    (idle_cnt == TIMEOUT_CYCLES - 16'd1);
    assign busy   = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        commit      = 1'b0;
        commit_zero = 1'b0;
        err         = 1'b0;
        if (state != ST_IDLE && bus.cs) begin
            state_next = ST_IDLE;
            err        = 1'b1;
        end else if (take) begin
            case (state)
                ST_IDLE: begin
                    if (bus.data == HDR_SET)      state_next  = ST_R;
                    else if (bus.data == HDR_OFF) commit_zero = 1'b1;
                    else                          err         = 1'b1;
                end
                ST_R: state_next = ST_G;
                ST_G: state_next = ST_B;
                ST_B: state_next = ST_W;
`ifdef RGBW_FRAME_CHECKSUM_EN
                ST_W: state_next = ST_CHK;
                ST_CHK: begin
                    state_next = ST_IDLE;
                    if (bus.data == chk_acc) commit = 1'b1;
                    else                     err    = 1'b1;
                end
`else
                ST_W: begin
                    state_next = ST_IDLE;
                    commit     = 1'b1;
                end
`endif
                default: state_next = ST_IDLE;
            endcase
        end else if (expire) begin
            state_next = ST_IDLE;
            err        = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_q     <= 1'b0;
            idle_cnt  <= '0;
            shadow_r  <= '0;
            shadow_g  <= '0;
            shadow_b  <= '0;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            white     <= '0;
            update    <= 1'b0;
            frame_err <= 1'b0;
`ifdef RGBW_FRAME_CHECKSUM_EN
            shadow_w  <= '0;
            chk_acc   <= '0;
`endif
        end else begin
            rdy_q     <= bus.rdy;
            update    <= commit || commit_zero;
            frame_err <= err;

            if (state == ST_IDLE || take)   idle_cnt <= '0;
            else if (TIMEOUT_CYCLES != '0)  idle_cnt <= idle_cnt + 16'd1;

            if (take) begin
                case (state)
                    ST_R: shadow_r <= bus.data;
                    ST_G: shadow_g <= bus.data;
                    ST_B: shadow_b <= bus.data;
`ifdef RGBW_FRAME_CHECKSUM_EN
                    ST_W: shadow_w <= bus.data;
`endif
                    default: ;
                endcase
            end

`ifdef RGBW_FRAME_CHECKSUM_EN
            // Running XOR seeded by the header byte; compared against the byte taken in CHK.
            if (take) chk_acc <= (state == ST_IDLE) ? bus.data : (chk_acc ^ bus.data);
`endif

            if (commit_zero) begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
                white <= '0;
            end else if (commit) begin
                red   <= shadow_r;
                green <= shadow_g;
                blue  <= shadow_b;
`ifdef RGBW_FRAME_CHECKSUM_EN
                white <= shadow_w;
`else
                // White arrives on the committing cycle itself, straight from the bus.
                white <= bus.data;
`endif
            end
        end
    end

endmodule
